md_unit: RTL
============

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
- Sits beside the ALU, downstream of the register file: consumes rs/rt read data and a decoded MD opcode from the controller.
- Executes mult, multu, div, divu, mthi and mtlo. Its HI/LO outputs feed the register-file write-data mux for mfhi/mflo.
- Exposes busy so pipeline hazard logic can stall dependent MD instructions.

Parameters:
MULT_CYCLES, 5, busy duration for mult/multu (>=1)
DIV_CYCLES, 10, busy duration for div/divu (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  operation valid this cycle (decode stage asserts for one cycle per instruction)
mdop  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
a  input  32  rs operand
b  input  32  rt operand
busy  output  1  arithmetic operation in progress
hi  output  32  current HI register
lo  output  32  current LO register

Behaviour:
- Reset (async, any time, including mid-operation): busy=0, hi=0, lo=0, counter=0. Pending result is discarded.
- Idle = busy low. An operation is accepted only when start=1 and busy=0 at a rising edge. start while busy=1 is ignored with no state change.
- Accepted mdop 1-4 at edge E (end of cycle 0):
  - latch result into pending hi/lo;
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - busy=1 in cycles 1..N.
- At the edge ending cycle N, commit the pending value to hi/lo; busy=0 in cycle N+1.
- A new start in cycle N+1 is accepted (back-to-back, no dead cycle).
- hi/lo keep their old values throughout cycles 1..N.
- Counter decrements once per cycle while busy. busy is a registered output (counter != 0), never combinational from start.
- mult: signed 32x32 -> 64; hi = product[63:32], lo = product[31:0].
- multu: same, operands unsigned.
- div: lo = quotient truncated toward zero; hi = remainder, which takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient and remainder.
- Divide by zero (b=0, div or divu):
  - busy still runs DIV_CYCLES;
  - hi/lo are left unchanged at commit.
- mthi/mtlo: when accepted (start=1, busy=0), write a into hi or lo at that edge, visible in cycle 1.
  - busy stays 0; single-cycle.
- mdop 0/7 with start: no effect.
- Any mdop while busy: ignored. Hazard logic stalls instead.
- Outputs hi/lo are the register values directly. No read bypass of pending results.

Decomposition:
- Shared package md_pkg: the MDOP_* opcode constants (width 3), MULT_CYCLES/DIV_CYCLES defaults. The controller uses the same encoding.
- One natural sub-module, md_arith: purely combinational.
  - Inputs: mdop, a, b.
  - Outputs: 64-bit {hi,lo} result and a div_by_zero flag.
- md_unit itself holds counter, pending registers, hi/lo and the accept/commit control.

Test Plan:
- mult a=0xFFFFFFFD, b=7, start at cycle 0 -> busy=1 cycles 1-5, busy=0 cycle 6; from cycle 6 hi=0xFFFFFFFF, lo=0xFFFFFFEB; hi/lo unchanged in cycles 1-5.
- multu a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Immediately followed (cycle 6) by divu a=7, b=2 -> accepted; busy cycles 7-16; hi=1, lo=3 from cycle 17.
- div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload mthi 0x1234, mtlo 0x5678. Then div a=5, b=0 -> busy 10 cycles, hi=0x1234, lo=0x5678 afterwards.
- During a mult busy window, drive start with mtlo a=0xDEAD and with mult a=2, b=3 -> both ignored; final lo equals the first mult's result; busy length unchanged.
- Start div, assert reset asynchronously mid-cycle 4 -> busy, hi, lo go to 0 without waiting for a clock edge. After release, mult 3x4 -> lo=12, hi=0 after 5 busy cycles.

Source files
------------

// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: opcode encoding used by both the controller
// and md_unit, plus default operation latencies.
package md_pkg;

  localparam logic [2:0] MDOP_NONE  = 3'd0;
  localparam logic [2:0] MDOP_MULT  = 3'd1;
  localparam logic [2:0] MDOP_MULTU = 3'd2;
  localparam logic [2:0] MDOP_DIV   = 3'd3;
  localparam logic [2:0] MDOP_DIVU  = 3'd4;
  localparam logic [2:0] MDOP_MTHI  = 3'd5;
  localparam logic [2:0] MDOP_MTLO  = 3'd6;
  localparam logic [2:0] MDOP_RSVD  = 3'd7;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Operations that occupy the unit for multiple cycles and commit through the pending registers.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == MDOP_MULT) || (op == MDOP_MULTU) || (op == MDOP_DIV) || (op == MDOP_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath. Produces the {hi,lo} image of the operation
// and flags division by zero so the caller can suppress the commit.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] divisor;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    // The low 64 bits of a product of sign-extended operands equal the signed product.
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};

    // Signed division works on magnitudes so 0x80000000 / -1 never overflows the divider;
    // the quotient wraps back to 0x80000000 after sign restoration.
    signed_div  = (mdop == MDOP_DIV);
    mag_a       = (signed_div && a[31]) ? -a : a;
    mag_b       = (signed_div && b[31]) ? -b : b;
    div_by_zero = (b == 32'd0) && ((mdop == MDOP_DIV) || (mdop == MDOP_DIVU));
    divisor     = (b == 32'd0) ? 32'd1 : mag_b;
    uq          = mag_a / divisor;
    ur          = mag_a % divisor;
    quot        = (signed_div && (a[31] ^ b[31])) ? -uq : uq;
    rem         = (signed_div && a[31]) ? -ur : ur;

    result = 64'd0;
    case (mdop)
      MDOP_MULT:            result = prod_s;
      MDOP_MULTU:           result = prod_u;
      MDOP_DIV, MDOP_DIVU:  result = {rem, quot};
      default:              result = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers. Arithmetic results are
// computed at accept, held in pending registers, and committed when the busy window ends.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic [63:0]      pend;
  logic             pend_dz;
  logic [63:0]      arith_result;
  logic             arith_dz;
  logic             accept;
  logic             accept_arith;
  logic             commit;
  logic [CNT_W-1:0] load_cnt;

  md_arith u_arith (
    .mdop        (mdop),
    .a           (a),
    .b           (b),
    .result      (arith_result),
    .div_by_zero (arith_dz)
  );

  // Handshake: start is a valid strobe, !busy is ready; a transfer happens only on an
  // edge where both hold. start while busy is dropped, never queued.
  always_comb begin
    accept       = start && !busy_q;
    accept_arith = accept && is_arith(mdop);
    commit       = busy_q && (cnt == CNT_W'(1));
    load_cnt     = ((mdop == MDOP_DIV) || (mdop == MDOP_DIVU)) ? CNT_W'(DIV_CYCLES)
                                                               : CNT_W'(MULT_CYCLES);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      busy_q  <= 1'b0;
      pend    <= 64'd0;
      pend_dz <= 1'b0;
    end else if (accept_arith) begin
      cnt     <= load_cnt;
      busy_q  <= 1'b1;
      pend    <= arith_result;
      pend_dz <= arith_dz;
    end else if (busy_q) begin
      cnt     <= cnt - CNT_W'(1);
      busy_q  <= (cnt != CNT_W'(1));
    end
  end

  // mthi/mtlo can only be accepted while idle, so they never collide with a commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else begin
      if (accept && (mdop == MDOP_MTHI))
        hi <= a;
      else if (commit && !pend_dz)
        hi <= pend[63:32];

      if (accept && (mdop == MDOP_MTLO))
        lo <= a;
      else if (commit && !pend_dz)
        lo <= pend[31:0];
    end
  end

  assign busy = busy_q;

endmodule
